// File: rtl/inst_mem_mc.sv
// inst_mem_mc: instruction memory with one write port and NUM_RD
// independent credit-flowed read channels, one storage copy each.
module inst_mem_mc #(
    parameter int    DW             = 32,
    parameter int    DEPTH          = 512,
    parameter int    AW             = 9,
    parameter int    NUM_RD         = 2,
    parameter int    RD_LAT         = 1,
    parameter string RDW_MODE       = "OLD",
    parameter int    CLEAR_ON_RESET = 0,
    parameter int    OBUF_DEPTH     = RD_LAT + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    output logic                 wr_ready,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [DW/8-1:0]      wr_be,
    input  logic [NUM_RD-1:0]    rd_req_valid,
    output logic [NUM_RD-1:0]    rd_req_ready,
    input  logic [NUM_RD*AW-1:0] rd_req_addr,
    output logic [NUM_RD-1:0]    rd_resp_valid,
    input  logic [NUM_RD-1:0]    rd_resp_ready,
    output logic [NUM_RD*DW-1:0] rd_resp_data,
    output logic                 busy
);
    localparam int BW = DW / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam bit NEW_MODE = (RDW_MODE == "NEW");
    localparam bit DO_CLEAR = (CLEAR_ON_RESET != 0);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] clr_cnt;
    logic          run_q, clearing, w_fire, w_ok;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [BW-1:0] w_be;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= DO_CLEAR ? S_CLEAR : S_RUN;
            clr_cnt <= '0;
            run_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            run_q <= (state == S_RUN);
        end
    end

    always_comb begin
        state_nx = state;
        if (state == S_CLEAR && clr_cnt == AW'(DEPTH - 1)) state_nx = S_RUN;
    end

    // Ready is delayed one cycle behind RUN so it only follows registered state.
    always_comb begin
        busy     = rst ? (state == S_CLEAR) : DO_CLEAR;
        wr_ready = rst & run_q;
        clearing = rst & (state == S_CLEAR);
        w_fire   = clearing | (wr_en & wr_ready);
        w_addr   = clearing ? clr_cnt : wr_addr;
        w_data   = clearing ? '0 : wr_data;
        w_be     = clearing ? '1 : wr_be;
        w_ok     = w_fire & (32'(w_addr) < DEPTH);
    end

    for (genvar c = 0; c < NUM_RD; c++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] fb [OBUF_DEPTH];
        logic [DW-1:0] p_d [RD_LAT];
        logic [RD_LAT-1:0] p_v;
        logic [AW-1:0] ra;
        logic [DW-1:0] old_w, new_w, rd_w;
        logic [PW-1:0] wp, rp;
        logic [CW-1:0] fcnt, cred;
        logic rdy, vld, acc, push, pop;

        assign ra    = rd_req_addr[c*AW +: AW];
        assign rdy   = rst & run_q & (cred < CW'(OBUF_DEPTH));
        assign vld   = rst & (fcnt != '0);
        assign acc   = rd_req_valid[c] & rdy;
        assign pop   = vld & rd_resp_ready[c];
        assign push  = p_v[RD_LAT-1];
        assign old_w = (32'(ra) < DEPTH) ? mem[ra[IW-1:0]] : '0;

        assign rd_req_ready[c]            = rdy;
        assign rd_resp_valid[c]           = vld;
        assign rd_resp_data[c*DW +: DW]   = vld ? fb[rp] : '0;

        always_comb begin
            new_w = old_w;
            for (int b = 0; b < BW; b++)
                if (w_be[b]) new_w[b*8 +: 8] = w_data[b*8 +: 8];
        end

        assign rd_w = (NEW_MODE && w_ok && w_addr == ra) ? new_w : old_w;

        always_ff @(posedge clk) begin
            if (w_ok)
                for (int b = 0; b < BW; b++)
                    if (w_be[b]) mem[w_addr[IW-1:0]][b*8 +: 8] <= w_data[b*8 +: 8];
        end

        always_ff @(posedge clk) begin
            p_d[0] <= rd_w;
            for (int i = 1; i < RD_LAT; i++) p_d[i] <= p_d[i-1];
            if (push) fb[wp] <= p_d[RD_LAT-1];
        end

        // Credits cover both the RAM pipeline and the buffer, so pushes never overflow.
        always_ff @(posedge clk) begin
            if (!rst) begin
                p_v  <= '0;
                wp   <= '0;
                rp   <= '0;
                fcnt <= '0;
                cred <= '0;
            end else begin
                p_v[0] <= acc;
                for (int i = 1; i < RD_LAT; i++) p_v[i] <= p_v[i-1];
                if (push) wp <= (wp == PW'(OBUF_DEPTH - 1)) ? '0 : wp + 1'b1;
                if (pop)  rp <= (rp == PW'(OBUF_DEPTH - 1)) ? '0 : rp + 1'b1;
                fcnt <= fcnt + CW'(push) - CW'(pop);
                cred <= cred + CW'(acc) - CW'(pop);
            end
        end
    end
endmodule
